pipe_regfile: RTL and testbench
===============================

PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of architectural registers (2..32).
REQ-003 SHALL have parameter ADDR_W, default 5, register address width; NUM_REGS <= 2**ADDR_W.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have one clock and asynchronous active-high reset: `clk` (in, 1), rising-edge clock; `reset` (in, 1), asynchronous active-high reset.
REQ-006 SHALL have ports `rs` (in, ADDR_W, read port A address) and `rt` (in, ADDR_W, read port B address).
REQ-007 SHALL have ports `A` (out, DATA_W, port A read data) and `B` (out, DATA_W, port B read data).
REQ-008 SHALL have ports `rd` (in, ADDR_W, write address), `write_data` (in, DATA_W, write data) and `reg_write` (in, 1, write enable).
REQ-009 SHALL have ports `busy_set` (in, 1, mark a destination pending) and `busy_rd` (in, ADDR_W, pending destination address).
REQ-010 SHALL have ports `rs_busy` (out, 1, rs has a pending write) and `rt_busy` (out, 1, rt has a pending write).

Function
REQ-011 SHALL capture write_data into register[rd] on the rising clk edge when reg_write=1 and reset=0.
REQ-012 SHALL drive A/B combinationally from register[rs]/register[rt].
REQ-013 SHALL forward write_data to A (or B) in the same cycle when reg_write=1 and rd equals rs (or rt), giving zero-latency write-to-read.
REQ-014 SHALL return 0 on A/B for any address >= NUM_REGS, and SHALL ignore writes to such addresses.
REQ-015 With ZERO_REG=1: reads of address 0 SHALL return 0; writes to 0 are ignored and not forwarded; busy_set to 0 is ignored.
REQ-016 SHALL keep one busy bit per register: set on the rising edge when busy_set=1 for busy_rd; cleared on the rising edge when reg_write=1 for rd.
REQ-017 When set and clear target the same register in one cycle, set SHALL win, so the bit ends at 1 (newer producer).
REQ-018 rs_busy/rt_busy SHALL be combinational from the busy bits, except that a same-cycle reg_write to that address (clear, no set) SHALL force 0, consistent with the forwarding.
REQ-019 Out-of-range addresses SHALL never report busy.

Reset
REQ-020 Asserting reset SHALL immediately clear all registers and all busy bits, independent of clk.
REQ-021 While reset=1: A=0, B=0, rs_busy=0, rt_busy=0; reg_write and busy_set are ignored and not forwarded.
REQ-022 Reset asserted mid-operation SHALL discard any same-edge write; the first write is accepted on the first rising edge with reset=0.

Structure
REQ-023 Shared package regfile_pkg SHALL hold the DATA_W/NUM_REGS/ADDR_W defaults and the data-word and address typedefs.
REQ-024 Busy-bit logic SHALL be a sub-module regfile_scoreboard (parameters NUM_REGS, ADDR_W, ZERO_REG), instantiated once.
REQ-025 Storage SHALL be a flop array sized exactly NUM_REGS, with no hard-coded initial contents.

Verification
REQ-026 Reset, then read rs=5, rt=10 -> A=0, B=0, rs_busy=rt_busy=0.
REQ-027 Write rd=7, data 0x964EA; next cycle rs=7 -> A=0x964EA. Write rd=4, data 0x0E311 with rs=4 in the same cycle -> A=0x0E311 before the edge (bypass).
REQ-028 ZERO_REG=1: write rd=0, data 0xFFFFFFFF; read rs=0 -> A=0, including the write cycle. busy_set with busy_rd=0 -> rs_busy stays 0.
REQ-029 busy_set with busy_rd=8, then rs=8 -> rs_busy=1. Later reg_write rd=8 -> rs_busy=0 in that cycle, and the bit is 0 after the edge. Same-cycle busy_set and reg_write on rd=8 -> rs_busy=1 after the edge.
REQ-030 NUM_REGS=16, ADDR_W=5: write rd=20, data 0x1230B; read rs=20 -> A=0; register 4 unchanged; rs_busy=0.
REQ-031 With registers nonzero and busy bits set, pulse reset between clock edges -> all reads 0 and busy outputs 0 immediately; a write on the same edge as reset deassertion is dropped.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined register file.
// Holds the default geometry and the word/address types used by the
// register file, its busy scoreboard and anything that talks to them.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned ADDR_W_DEF   = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   set_en, set_addr      mark a destination as pending
//   clr_en, clr_addr      retire a pending destination (the register write)
//   rs, rt                lookup addresses
//   rs_busy, rt_busy      pending status for rs/rt
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                set_ok;
  logic                clr_ok;
  logic                rs_hit;
  logic                rt_hit;

  assign set_ok = set_en && (32'(set_addr) < NUM_REGS) &&
                  !((ZERO_REG != 0) && (set_addr == '0));
  assign clr_ok = clr_en && (32'(clr_addr) < NUM_REGS);

  // Set is applied after clear so a newer producer keeps the bit.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (clr_ok && (clr_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (set_ok && (set_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Lookup by match loop; out-of-range addresses simply never hit.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rs == ADDR_W'(i)) rs_hit = busy_q[i];
      if (rt == ADDR_W'(i)) rt_hit = busy_q[i];
    end
  end

  // A same-cycle write to the address is being forwarded, so it is not busy
  // unless a new producer claims that register in the same cycle.
  always_comb begin
    rs_busy = rs_hit;
    rt_busy = rt_hit;
    if (clr_ok && (clr_addr == rs) && !(set_ok && (set_addr == rs))) rs_busy = 1'b0;
    if (clr_ok && (clr_addr == rt) && !(set_ok && (set_addr == rt))) rt_busy = 1'b0;
    if (reset) begin
      rs_busy = 1'b0;
      rt_busy = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Two-read, one-write register file with same-cycle write forwarding and a
// busy scoreboard for pending destinations.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   rs, rt / A, B                  read addresses / combinational read data
//   rd, write_data, reg_write      write port
//   busy_set, busy_rd              mark destination busy_rd as pending
//   rs_busy, rt_busy               pending status of rs/rt
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_rd,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;
  logic              rs_ok;
  logic              rt_ok;

  // Readable/writable: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_en = !reset && reg_write && addr_ok(rd);
  assign rs_ok = !reset && addr_ok(rs);
  assign rt_ok = !reset && addr_ok(rt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (rd == ADDR_W'(i)) regs_q[i] <= write_data;
      end
    end
  end

  always_comb begin
    A = '0;
    B = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rs == ADDR_W'(i)) A = regs_q[i];
      if (rt == ADDR_W'(i)) B = regs_q[i];
    end
    if (wr_en && (rd == rs)) A = write_data;
    if (wr_en && (rd == rt)) B = write_data;
    if (!rs_ok) A = '0;
    if (!rt_ok) B = '0;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (busy_set),
    .set_addr (busy_rd),
    .clr_en   (reg_write),
    .clr_addr (rd),
    .rs       (rs),
    .rt       (rt),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy)
  );

endmodule

// File: tb/tb_pipe_regfile.sv
module tb_pipe_regfile;
  import regfile_pkg::*;

  localparam int unsigned NR = 16;

  logic  clk = 1'b0;
  logic  reset;
  addr_t rs, rt, rd, busy_rd;
  word_t write_data;
  logic  reg_write, busy_set;
  word_t A, B;
  logic  rs_busy, rt_busy;

  int errors = 0;
  int checks = 0;

  word_t m_reg  [NR];
  bit    m_busy [NR];

  pipe_regfile #(
    .DATA_W   (32),
    .NUM_REGS (NR),
    .ADDR_W   (5),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs         (rs),
    .rt         (rt),
    .A          (A),
    .B          (B),
    .rd         (rd),
    .write_data (write_data),
    .reg_write  (reg_write),
    .busy_set   (busy_set),
    .busy_rd    (busy_rd),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy)
  );

  always #5 clk = ~clk;

  // Reference behaviour of the register file.
  function automatic word_t exp_rd(input addr_t a);
    if (reset || a >= NR || a == 0) return '0;
    if (reg_write && rd == a) return write_data;
    return m_reg[a];
  endfunction

  function automatic word_t exp_busy(input addr_t a);
    if (reset || a >= NR) return '0;
    if (reg_write && rd == a && !(busy_set && busy_rd == a)) return '0;
    return word_t'(m_busy[a]);
  endfunction

  task automatic chk(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_A"}, A, exp_rd(rs));
    chk({tag, "_B"}, B, exp_rd(rt));
    chk({tag, "_rs_busy"}, word_t'(rs_busy), exp_busy(rs));
    chk({tag, "_rt_busy"}, word_t'(rt_busy), exp_busy(rt));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance one clock edge and apply the architectural effect of the inputs.
  task automatic edge_update();
    @(posedge clk);
    if (!reset) begin
      if (reg_write && rd < NR) begin
        if (rd != 0) m_reg[rd] = write_data;
        m_busy[rd] = 1'b0;
      end
      if (busy_set && busy_rd < NR && busy_rd != 0) m_busy[busy_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reg_write  = 1'b0;
    busy_set   = 1'b0;
    rd         = '0;
    busy_rd    = '0;
    write_data = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rs = 5'd5;
    rt = 5'd10;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Post-reset reads
    #1;
    chk("rst_A", A, '0);
    chk("rst_B", B, '0);
    chk("rst_rs_busy", word_t'(rs_busy), '0);
    chk("rst_rt_busy", word_t'(rt_busy), '0);

    // Write then read, and same-cycle bypass
    rd = 5'd7; write_data = 32'h964EA; reg_write = 1'b1;
    edge_update();
    idle(); rs = 5'd7;
    #1 chk("wr_rd7", A, 32'h964EA);
    rd = 5'd4; write_data = 32'h0E311; reg_write = 1'b1; rs = 5'd4;
    #1 chk("bypass_rd4", A, 32'h0E311);
    edge_update();

    // Zero register
    idle(); rd = 5'd0; write_data = 32'hFFFF_FFFF; reg_write = 1'b1; rs = 5'd0;
    #1 chk("zero_wr_cycle", A, '0);
    edge_update();
    idle(); rs = 5'd0;
    #1 chk("zero_after", A, '0);
    busy_set = 1'b1; busy_rd = 5'd0;
    edge_update();
    idle();
    #1 chk("zero_busy", word_t'(rs_busy), '0);

    // Busy set / clear / set-wins
    busy_set = 1'b1; busy_rd = 5'd8;
    edge_update();
    idle(); rs = 5'd8;
    #1 chk("busy8_set", word_t'(rs_busy), 32'd1);
    reg_write = 1'b1; rd = 5'd8; write_data = 32'hA5A5;
    #1 chk("busy8_clr_fwd", word_t'(rs_busy), '0);
    chk("busy8_fwd_A", A, 32'hA5A5);
    edge_update();
    idle();
    #1 chk("busy8_cleared", word_t'(rs_busy), '0);
    busy_set = 1'b1; busy_rd = 5'd8; reg_write = 1'b1; rd = 5'd8; write_data = 32'h77;
    edge_update();
    idle();
    #1 chk("busy8_set_wins", word_t'(rs_busy), 32'd1);

    // Out-of-range address
    rd = 5'd20; write_data = 32'h1230B; reg_write = 1'b1;
    edge_update();
    idle(); rs = 5'd20; rt = 5'd4;
    #1 chk("oor_A", A, '0);
    chk("oor_reg4", B, 32'h0E311);
    chk("oor_busy", word_t'(rs_busy), '0);

    // Reset pulse between edges
    rs = 5'd7; rt = 5'd8;
    #1 chk("pre_rst_A", A, 32'h964EA);
    chk("pre_rst_busy", word_t'(rt_busy), 32'd1);
    reset = 1'b1;
    #1 chk("rst_mid_A", A, '0);
    chk("rst_mid_B", B, '0);
    chk("rst_mid_busy", word_t'(rt_busy), '0);
    model_clear();
    reg_write = 1'b1; rd = 5'd3; write_data = 32'h55;
    edge_update();
    reset = 1'b0;
    idle(); rs = 5'd3; rt = 5'd7;
    #1 chk("rst_drop_wr", A, '0);
    chk("rst_clr_r7", B, '0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rs         = addr_t'($urandom_range(0, 19));
      rt         = addr_t'($urandom_range(0, 19));
      rd         = addr_t'($urandom_range(0, 19));
      busy_rd    = addr_t'($urandom_range(0, 19));
      write_data = $urandom;
      reg_write  = ($urandom_range(0, 1) == 1);
      busy_set   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) busy_rd = rd;
      #1 check_outs("rnd");
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1 check_outs("rnd_rst");
        model_clear();
        edge_update();
        reset = 1'b0;
      end else begin
        edge_update();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
